axi_lite_data_mem: RTL and testbench

AXI4-lite slave data memory: the downstream consumer of the CPU core's AXI4-lite master load/store port. Accepts single-beat reads and writes, stores data in a single-port synchronous word RAM (block-RAM inferable), and returns OKAY/SLVERR responses. Sits between `cpu` and the board-level memory map as the default data RAM.

---
 rtl/axi_lite_data_mem_if.sv | 34 +++
 rtl/axi_lite_data_mem.sv | 141 ++++++++++++++
 tb/tb_axi_lite_data_mem.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_data_mem_if.sv
// rtl/axi_lite_data_mem_if.sv - AXI4-lite bundle between the CPU load/store master and the data RAM
interface axi_lite_data_mem_if;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_lite_data_mem.sv
// rtl/axi_lite_data_mem.sv - AXI4-lite slave single-port word RAM
// Optional AXI_LITE_DATA_MEM_RANGE_CHECK_EN: out-of-range addresses get SLVERR, no RAM access.
module axi_lite_data_mem #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                clk,
    input  logic                rst,
    axi_lite_data_mem_if.slave  axi
);

    typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

    w_state_t r_w_state, w_w_state_nxt;
    r_state_t r_r_state, w_r_state_nxt;

    logic        r_aw_latched;
    logic        r_w_latched;
    logic [31:0] r_awaddr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [1:0]  r_bresp;
    logic        r_ar_oor;
    logic [31:0] r_ram_q;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;
    logic [31:0] r_mem [0:(1 << ADDR_WIDTH) - 1];

    logic                  w_awready, w_wready, w_arready;
    logic                  w_aw_hs, w_w_hs, w_ar_hs;
    logic                  w_aw_oor, w_ar_oor;
    logic                  w_commit;
    logic [ADDR_WIDTH-1:0] w_ram_addr;

`ifdef AXI_LITE_DATA_MEM_RANGE_CHECK_EN
    assign w_aw_oor = |r_awaddr[31:ADDR_WIDTH+2];
    assign w_ar_oor = |axi.araddr[31:ADDR_WIDTH+2];
`else
    assign w_aw_oor = 1'b0;
    assign w_ar_oor = 1'b0;
`endif

    wire w_unused = &{1'b0, axi.awprot, axi.arprot, r_awaddr[1:0], axi.araddr[1:0],
                      r_awaddr[31:ADDR_WIDTH+2], axi.araddr[31:ADDR_WIDTH+2]};

    assign w_awready = !rst && (r_w_state == W_IDLE) && !r_aw_latched;
    assign w_wready  = !rst && (r_w_state == W_IDLE) && !r_w_latched;
    // The commit owns the single RAM port, so reads are held off for that one cycle.
    assign w_arready = !rst && (r_r_state == R_IDLE) && (r_w_state != W_COMMIT);

    assign w_aw_hs  = axi.awvalid && w_awready;
    assign w_w_hs   = axi.wvalid  && w_wready;
    assign w_ar_hs  = axi.arvalid && w_arready;
    assign w_commit = (r_w_state == W_COMMIT);
    assign w_ram_addr = w_commit ? r_awaddr[ADDR_WIDTH+1:2] : axi.araddr[ADDR_WIDTH+1:2];

    assign axi.awready = w_awready;
    assign axi.wready  = w_wready;
    assign axi.arready = w_arready;
    assign axi.bvalid  = (r_w_state == W_RESP);
    assign axi.bresp   = r_bresp;
    assign axi.rvalid  = (r_r_state == R_DATA);
    assign axi.rdata   = r_rdata;
    assign axi.rresp   = r_rresp;

    always_comb begin
        w_w_state_nxt = r_w_state;
        case (r_w_state)
            W_IDLE:   if ((r_aw_latched || w_aw_hs) && (r_w_latched || w_w_hs))
                          w_w_state_nxt = W_COMMIT;
            W_COMMIT: w_w_state_nxt = W_RESP;
            W_RESP:   if (axi.bready) w_w_state_nxt = W_IDLE;
            default:  w_w_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_r_state_nxt = r_r_state;
        case (r_r_state)
            R_IDLE:  if (w_ar_hs) w_r_state_nxt = R_WAIT;
            R_WAIT:  w_r_state_nxt = R_DATA;
            R_DATA:  if (axi.rready) w_r_state_nxt = R_IDLE;
            default: w_r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_w_state    <= W_IDLE;
            r_aw_latched <= 1'b0;
            r_w_latched  <= 1'b0;
            r_bresp      <= 2'b00;
        end else begin
            r_w_state <= w_w_state_nxt;
            if (w_aw_hs) begin
                r_aw_latched <= 1'b1;
                r_awaddr     <= axi.awaddr;
            end
            if (w_w_hs) begin
                r_w_latched <= 1'b1;
                r_wdata     <= axi.wdata;
                r_wstrb     <= axi.wstrb;
            end
            if (w_commit)
                r_bresp <= w_aw_oor ? 2'b10 : 2'b00;
            if ((r_w_state == W_RESP) && axi.bready) begin
                r_aw_latched <= 1'b0;
                r_w_latched  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_r_state <= R_IDLE;
            r_ar_oor  <= 1'b0;
            r_rdata   <= 32'd0;
            r_rresp   <= 2'b00;
        end else begin
            r_r_state <= w_r_state_nxt;
            if (w_ar_hs)
                r_ar_oor <= w_ar_oor;
            if (r_r_state == R_WAIT) begin
                r_rdata <= r_ar_oor ? 32'd0 : r_ram_q;
                r_rresp <= r_ar_oor ? 2'b10 : 2'b00;
            end
        end
    end

    // Contents are not reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_commit && !w_aw_oor) begin
            for (int b = 0; b < 4; b++)
                if (r_wstrb[b])
                    r_mem[w_ram_addr][8*b +: 8] <= r_wdata[8*b +: 8];
        end else if (w_ar_hs) begin
            r_ram_q <= r_mem[w_ram_addr];
        end
    end

endmodule

// File: tb/tb_axi_lite_data_mem.sv
// tb/tb_axi_lite_data_mem.sv - directed and randomized bench for axi_lite_data_mem with a word-array model
module tb_axi_lite_data_mem;

    localparam int AW = 14;
`ifdef AXI_LITE_DATA_MEM_RANGE_CHECK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks;
    int   failures;

    logic [31:0] mem_m [int];
    logic [31:0] r_addr, r_data;
    logic [3:0]  r_strb;
    int          r_lead, r_dly;

    axi_lite_data_mem_if bus ();

    axi_lite_data_mem #(.ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .axi (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & ((32'd1 << AW) - 32'd1));
    endfunction

    function automatic bit oor(input logic [31:0] a);
        return RANGE_CHK && ((a >> (AW + 2)) != 32'd0);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        if (!oor(a)) begin
            w = mem_m.exists(widx(a)) ? mem_m[widx(a)] : 32'd0;
            for (int b = 0; b < 4; b++)
                if (s[b]) w[8*b +: 8] = d[8*b +: 8];
            mem_m[widx(a)] = w;
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        return oor(a) ? 32'd0 : mem_m[widx(a)];
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        return oor(a) ? 2'b10 : 2'b00;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W.
    task automatic send_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int lead);
        bit aw_done, w_done, aw_hs, w_hs;
        int cyc;
        aw_done = 0;
        w_done  = 0;
        cyc     = 0;
        bus.awaddr = a;
        bus.awprot = 3'($urandom);
        bus.wdata  = d;
        bus.wstrb  = s;
        if (lead >= 0) bus.wvalid = 1'b1;
        if (lead <= 0) bus.awvalid = 1'b1;
        while (!(aw_done && w_done) && cyc < 40) begin
            @(negedge clk);
            if (w_done && !aw_done) chk("wready_drop", bus.wready, 1'b0);
            if (aw_done && !w_done) chk("awready_drop", bus.awready, 1'b0);
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            step();
            if (aw_hs) begin bus.awvalid = 1'b0; aw_done = 1; end
            if (w_hs)  begin bus.wvalid  = 1'b0; w_done  = 1; end
            cyc++;
            if (lead > 0 && cyc == lead)  bus.awvalid = 1'b1;
            if (lead < 0 && cyc == -lead) bus.wvalid  = 1'b1;
        end
        if (!(aw_done && w_done)) begin
            chk("aw_w_timeout", 32'd0, 32'd1);
            bus.awvalid = 1'b0;
            bus.wvalid  = 1'b0;
        end
    endtask

    task automatic finish_b(input int dly, input logic [1:0] exp, input string tag);
        @(negedge clk);
        chk({tag, "_bvalid_commit"}, bus.bvalid, 1'b0);
        chk({tag, "_arready_commit"}, bus.arready, 1'b0);
        step();
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            chk({tag, "_bvalid_hold"}, bus.bvalid, 1'b1);
            chk({tag, "_bresp_hold"}, bus.bresp, exp);
            chk({tag, "_awready_hold"}, bus.awready, 1'b0);
            step();
        end
        bus.bready = 1'b1;
        @(negedge clk);
        chk({tag, "_bvalid"}, bus.bvalid, 1'b1);
        chk({tag, "_bresp"}, bus.bresp, exp);
        step();
        bus.bready = 1'b0;
        @(negedge clk);
        chk({tag, "_bvalid_done"}, bus.bvalid, 1'b0);
        chk({tag, "_awready_next"}, bus.awready, 1'b1);
        step();
    endtask

    task automatic send_ar(input logic [31:0] a);
        bit done, hs;
        int cyc;
        done = 0;
        cyc  = 0;
        bus.araddr  = a;
        bus.arprot  = 3'($urandom);
        bus.arvalid = 1'b1;
        while (!done && cyc < 40) begin
            @(negedge clk);
            hs = bus.arvalid && bus.arready;
            step();
            if (hs) begin bus.arvalid = 1'b0; done = 1; end
            cyc++;
        end
        if (!done) begin
            chk("ar_timeout", 32'd0, 32'd1);
            bus.arvalid = 1'b0;
        end
    endtask

    task automatic finish_r(input int dly, input logic [31:0] exp_d, input logic [1:0] exp_r, input string tag);
        @(negedge clk);
        chk({tag, "_rvalid_wait"}, bus.rvalid, 1'b0);
        step();
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            chk({tag, "_rvalid_hold"}, bus.rvalid, 1'b1);
            chk({tag, "_rdata_hold"}, bus.rdata, exp_d);
            chk({tag, "_rresp_hold"}, bus.rresp, exp_r);
            chk({tag, "_arready_hold"}, bus.arready, 1'b0);
            step();
        end
        bus.rready = 1'b1;
        @(negedge clk);
        chk({tag, "_rvalid"}, bus.rvalid, 1'b1);
        chk({tag, "_rdata"}, bus.rdata, exp_d);
        chk({tag, "_rresp"}, bus.rresp, exp_r);
        step();
        bus.rready = 1'b0;
        @(negedge clk);
        chk({tag, "_rvalid_done"}, bus.rvalid, 1'b0);
        chk({tag, "_arready_next"}, bus.arready, 1'b1);
        step();
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        bus.awvalid = 1'b0; bus.awaddr = '0; bus.awprot = '0;
        bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb  = '0;
        bus.bready  = 1'b0;
        bus.arvalid = 1'b0; bus.araddr = '0; bus.arprot = '0;
        bus.rready  = 1'b0;
        repeat (3) step();

        @(negedge clk);
        chk("rst_awready", bus.awready, 1'b0);
        chk("rst_wready", bus.wready, 1'b0);
        chk("rst_arready", bus.arready, 1'b0);
        chk("rst_bvalid", bus.bvalid, 1'b0);
        chk("rst_rvalid", bus.rvalid, 1'b0);
        chk("rst_bresp", bus.bresp, 2'b00);
        chk("rst_rresp", bus.rresp, 2'b00);
        chk("rst_rdata", bus.rdata, 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_awready", bus.awready, 1'b1);
        chk("post_rst_wready", bus.wready, 1'b1);
        chk("post_rst_arready", bus.arready, 1'b1);
        step();

        // Same-cycle AW/W, then full-word readback
        send_aw_w(32'h10, 32'hDEADBEEF, 4'hF, 0);
        model_write(32'h10, 32'hDEADBEEF, 4'hF);
        finish_b(0, 2'b00, "tp1_wr");
        send_ar(32'h10);
        finish_r(0, 32'hDEADBEEF, 2'b00, "tp1_rd");

        // W three cycles ahead of AW, partial strobe
        send_aw_w(32'h10, 32'h11223344, 4'b0101, 3);
        model_write(32'h10, 32'h11223344, 4'b0101);
        finish_b(0, 2'b00, "tp2_wr");
        send_ar(32'h13);
        finish_r(0, 32'hDE22BE44, 2'b00, "tp2_rd");

        // Response back-pressure for five cycles
        send_aw_w(32'h20, 32'h0F1E2D3C, 4'hF, -2);
        model_write(32'h20, 32'h0F1E2D3C, 4'hF);
        finish_b(5, 2'b00, "stall_wr");
        send_ar(32'h20);
        finish_r(5, 32'h0F1E2D3C, 2'b00, "stall_rd");

        // AR arrives in the commit cycle to the same word
        send_aw_w(32'h24, 32'hA5A50F0F, 4'hF, 0);
        model_write(32'h24, 32'hA5A50F0F, 4'hF);
        bus.araddr  = 32'h24;
        bus.arvalid = 1'b1;
        @(negedge clk);
        chk("arb_arready_commit", bus.arready, 1'b0);
        chk("arb_bvalid_commit", bus.bvalid, 1'b0);
        step();
        bus.bready = 1'b1;
        send_ar(32'h24);
        bus.bready = 1'b0;
        chk("arb_b_done", bus.bvalid, 1'b0);
        finish_r(0, 32'hA5A50F0F, 2'b00, "arb_rd");

        // Upper address bits: aliasing or SLVERR depending on build
        send_aw_w(32'h0, 32'h12345678, 4'hF, 0);
        model_write(32'h0, 32'h12345678, 4'hF);
        finish_b(0, 2'b00, "rng_base_wr");
        send_aw_w(32'h0001_0000, 32'hCAFEF00D, 4'hF, 1);
        model_write(32'h0001_0000, 32'hCAFEF00D, 4'hF);
        finish_b(0, exp_resp(32'h0001_0000), "rng_hi_wr");
        send_ar(32'h0);
        finish_r(0, exp_rd(32'h0), 2'b00, "rng_base_rd");
        send_ar(32'h0001_0000);
        finish_r(1, exp_rd(32'h0001_0000), exp_resp(32'h0001_0000), "rng_hi_rd");

        // Reset while a read sits in R_WAIT
        send_ar(32'h10);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_rwait_arready", bus.arready, 1'b0);
        chk("rst_rwait_awready", bus.awready, 1'b0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_rwait_no_rvalid", bus.rvalid, 1'b0);
            chk("rst_rwait_arready_back", bus.arready, 1'b1);
            step();
        end

        // Reset while the write response is pending; data already committed
        send_aw_w(32'h30, 32'h0BADCAFE, 4'hF, 0);
        model_write(32'h30, 32'h0BADCAFE, 4'hF);
        step();
        @(negedge clk);
        chk("rst_wresp_bvalid_before", bus.bvalid, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_wresp_no_bvalid", bus.bvalid, 1'b0);
            chk("rst_wresp_awready", bus.awready, 1'b1);
            chk("rst_wresp_wready", bus.wready, 1'b1);
            step();
        end

        // Reset with only W latched: no RAM update, latch discarded
        bus.wdata  = 32'hFFFFFFFF;
        bus.wstrb  = 4'hF;
        bus.wvalid = 1'b1;
        step();
        bus.wvalid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        send_aw_w(32'h34, 32'h55AA55AA, 4'hF, 0);
        model_write(32'h34, 32'h55AA55AA, 4'hF);
        finish_b(0, 2'b00, "rst_prew_wr");
        send_ar(32'h30);
        finish_r(0, exp_rd(32'h30), 2'b00, "rst_prew_rd30");
        send_ar(32'h34);
        finish_r(0, exp_rd(32'h34), 2'b00, "rst_prew_rd34");

        // Randomized traffic over words 16..23
        for (int w = 16; w < 24; w++) begin
            r_addr = 32'(w) << 2;
            r_data = $urandom;
            send_aw_w(r_addr, r_data, 4'hF, 0);
            model_write(r_addr, r_data, 4'hF);
            finish_b(0, 2'b00, "rnd_init");
        end
        for (int n = 0; n < 30; n++) begin
            r_addr = (32'($urandom_range(16, 23)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0)
                r_addr = r_addr | (32'($urandom_range(1, 3)) << (AW + 2));
            r_dly = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 1) begin
                r_data = $urandom;
                r_strb = 4'($urandom);
                r_lead = $urandom_range(0, 4) - 2;
                send_aw_w(r_addr, r_data, r_strb, r_lead);
                model_write(r_addr, r_data, r_strb);
                finish_b(r_dly, exp_resp(r_addr), "rnd_wr");
            end else begin
                send_ar(r_addr);
                finish_r(r_dly, exp_rd(r_addr), exp_resp(r_addr), "rnd_rd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
